// File: rtl/arb_client_mgr_if.sv
// Client-manager <-> arbiter/bus handshake bundle.
// master: clients/arbiter side; slave: arb_client_mgr side.
interface arb_client_mgr_if #(
  parameter int N  = 4,
  parameter int IW = 2
);
  logic [N-1:0]  REQ;
  logic [N-1:0]  GRANT;
  logic          RELEASE;
  logic [N-1:0]  PEND;
  logic          VALID;
  logic [IW-1:0] OWNER;
  logic          DONE;
  logic          ERR;

  modport master (
    output REQ, GRANT, RELEASE,
    input  PEND, VALID, OWNER, DONE, ERR
  );

  modport slave (
    input  REQ, GRANT, RELEASE,
    output PEND, VALID, OWNER, DONE, ERR
  );
endinterface

// File: rtl/arb_client_mgr.sv
// Requester-side manager for a lowest-index priority arbiter.
// Ports: CLK, RESETN (async low); bus: REQ/GRANT/RELEASE in, PEND/VALID/OWNER/DONE/ERR out.
// Optional grant check: define ARB_GRANT_CHECK_EN (else ERR is tied 0).
module arb_client_mgr #(
  parameter int N         = 4,
  parameter int BURST_LEN = 4,
  parameter int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic             CLK,
  input  logic             RESETN,
  arb_client_mgr_if.slave  bus
);

  localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(BURST_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [N-1:0]  pend, pend_nxt, clr;
  logic [IW-1:0] owner, owner_nxt, enc;
  logic          done, done_nxt;

  // Lowest set grant bit; an empty grant encodes as 0.
  always_comb begin
    enc = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.GRANT[i]) enc = IW'(i);
    end
  end

`ifdef ARB_GRANT_CHECK_EN
  logic err, err_nxt, g_bad;

  always_comb begin
    g_bad = (bus.GRANT == '0)
          | ((bus.GRANT & (bus.GRANT - N'(1))) != '0)
          | ((bus.GRANT & ~pend) != '0);
  end
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    owner_nxt = owner;
    done_nxt  = 1'b0;
    clr       = '0;
`ifdef ARB_GRANT_CHECK_EN
    err_nxt   = err;
`endif
    unique case (state)
      IDLE: begin
        if (pend != '0) begin
          owner_nxt = enc;
          cnt_nxt   = CNT_INIT;
          state_nxt = OWN;
`ifdef ARB_GRANT_CHECK_EN
          err_nxt   = err | g_bad;
`endif
        end
      end
      OWN: begin
        if (cnt == '0 || bus.RELEASE) begin
          clr[owner] = 1'b1;
          done_nxt   = 1'b1;
          state_nxt  = IDLE;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A new request on the retiring edge wins over the clear.
    pend_nxt = (pend & ~clr) | bus.REQ;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      owner <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      pend  <= pend_nxt;
      owner <= owner_nxt;
      done  <= done_nxt;
    end
  end

`ifdef ARB_GRANT_CHECK_EN
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) err <= 1'b0;
    else         err <= err_nxt;
  end

  assign bus.ERR = err;
`else
  assign bus.ERR = 1'b0;
`endif

  assign bus.PEND  = pend;
  assign bus.VALID = (state == OWN);
  assign bus.OWNER = owner;
  assign bus.DONE  = done;

endmodule

// File: tb/tb_arb_client_mgr.sv
// Randomized scoreboard bench for arb_client_mgr.
// Arbiter modelled as GRANT = PEND & -PEND, with an override for error tests.
module tb_arb_client_mgr;
  localparam int N  = 4;
  localparam int BL = 4;
  localparam int IW = 2;

  logic CLK = 1'b0;
  logic RESETN = 1'b0;
  always #5 CLK = ~CLK;

  arb_client_mgr_if #(.N(N), .IW(IW)) bus ();

  arb_client_mgr #(.N(N), .BURST_LEN(BL), .IW(IW)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .bus    (bus)
  );

  logic         ovr_en  = 1'b0;
  logic [N-1:0] ovr_val = '0;
  assign bus.GRANT = ovr_en ? ovr_val : (bus.PEND & (~bus.PEND + 4'd1));

  typedef struct { int owner; int len; } burst_t;
  burst_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state (state after the most recent edge)
  logic [N-1:0] m_pend;
  logic         m_busy, m_done, m_err;
  int           m_owner, m_used;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] g);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) if (g[i]) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_pend = '0; m_busy = 0; m_done = 0; m_err = 0;
    m_owner = 0; m_used = 0;
  endtask

  // Advance the model across one rising edge with the inputs now driven.
  task automatic model_step();
    logic [N-1:0] g;
    g = ovr_en ? ovr_val : (m_pend & (~m_pend + 4'd1));
    m_done = 0;
    if (!m_busy) begin
      if (m_pend != 0) begin
        m_owner = lowest(g);
        m_busy  = 1;
        m_used  = 0;
`ifdef ARB_GRANT_CHECK_EN
        if ($countones(g) != 1 || (g & ~m_pend) != 0) m_err = 1;
`endif
      end
    end else if (m_used + 1 == BL || bus.RELEASE) begin
      exp_q.push_back('{owner: m_owner, len: m_used + 1});
      m_pend[m_owner] = 1'b0;
      m_busy = 0;
      m_done = 1;
    end else begin
      m_used++;
    end
    m_pend = m_pend | bus.REQ;
  endtask

  task automatic check_outputs();
    chk("pend", 32'(bus.PEND), 32'(m_pend));
    chk("valid", 32'(bus.VALID), 32'(m_busy));
    chk("done", 32'(bus.DONE), 32'(m_done));
    chk("err", 32'(bus.ERR), 32'(m_err));
    if (m_busy) chk("owner", 32'(bus.OWNER), 32'(m_owner));
  endtask

  task automatic cyc(input logic [N-1:0] r, input logic rl);
    @(negedge CLK);
    check_outputs();
    bus.REQ     = r;
    bus.RELEASE = rl;
    model_step();
  endtask

  task automatic do_reset();
    bus.REQ = '0; bus.RELEASE = 1'b0; ovr_en = 1'b0;
    @(posedge CLK);
    #2 RESETN = 1'b0;
    #1;
    chk("rst_pend", 32'(bus.PEND), 0);
    chk("rst_valid", 32'(bus.VALID), 0);
    chk("rst_owner", 32'(bus.OWNER), 0);
    chk("rst_done", 32'(bus.DONE), 0);
    chk("rst_err", 32'(bus.ERR), 0);
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    #2 RESETN = 1'b1;
  endtask

  // Monitor: rebuild each observed burst and match it against the queue.
  logic mon_act = 1'b0;
  int   mon_owner, mon_len;
  always @(negedge CLK) begin
    if (!RESETN) begin
      mon_act = 1'b0;
    end else if (bus.VALID) begin
      if (!mon_act) begin
        mon_act   = 1'b1;
        mon_owner = int'(bus.OWNER);
        mon_len   = 1;
      end else begin
        mon_len++;
        chk("owner_stable", 32'(bus.OWNER), 32'(mon_owner));
      end
    end else if (mon_act) begin
      burst_t e;
      mon_act = 1'b0;
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL burst_unexpected: owner %0d len %0d, none expected",
                 mon_owner, mon_len);
      end else begin
        e = exp_q.pop_front();
        chk("burst_owner", 32'(mon_owner), 32'(e.owner));
        chk("burst_len", 32'(mon_len), 32'(e.len));
      end
    end
  end

  initial begin
    bit fired;
    int guard;
    bus.REQ = '0; bus.RELEASE = 1'b0;
    model_reset();
    do_reset();

    // Single request from client 2
    cyc(4'b0100, 0);
    repeat (8) cyc('0, 0);

    // Two clients in one cycle: 1 then 3
    cyc(4'b1010, 0);
    repeat (14) cyc('0, 0);

    // Early release on the second ownership cycle
    cyc(4'b0001, 0);
    repeat (6) cyc('0, m_busy && m_used == 1);

    // Re-request on the retiring edge
    cyc(4'b0001, 0);
    fired = 0;
    for (int i = 0; i < 14; i++) begin
      if (!fired && m_busy && m_owner == 0 && m_used == BL - 1) begin
        fired = 1;
        cyc(4'b0001, 0);
      end else begin
        cyc('0, 0);
      end
    end

    // Reset during a burst with two pending clients
    cyc(4'b0110, 0);
    cyc('0, 0);
    do_reset();
    repeat (4) cyc('0, 0);

`ifdef ARB_GRANT_CHECK_EN
    // Bad grant at capture sets a sticky error
    cyc(4'b0001, 0);
    ovr_en = 1'b1; ovr_val = 4'b0011;
    cyc('0, 0);
    ovr_en = 1'b0;
    repeat (12) cyc('0, 0);
`endif

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] r;
      r = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      cyc(r, $urandom_range(0, 7) == 0);
    end

    guard = 0;
    while ((m_busy || m_pend != 0) && guard < 200) begin
      cyc('0, 0);
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL drain_timeout: still busy after %0d cycles, need idle", guard);
    end
    repeat (3) cyc('0, 0);
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
